// File: rtl/axil_triggered_pulse_train.sv
// axil_triggered_pulse_train: counted pulse-train generator started by a register-block trigger strobe.
// Ports: clock/reset (async active-low); cfg_period/cfg_width/cfg_count/cfg_enable configuration;
// trigger start strobe; pulse_out train output; busy while running; done one-cycle completion strobe;
// status = {overrun, cfg_error, aborted, busy, 12'b0, emitted}.
module axil_triggered_pulse_train #(
    parameter int COUNTER_WIDTH = 16,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [COUNTER_WIDTH-1:0] cfg_period,
    input  logic [COUNTER_WIDTH-1:0] cfg_width,
    input  logic [COUNT_WIDTH-1:0]   cfg_count,
    input  logic                     cfg_enable,
    input  logic                     trigger,
    output logic                     pulse_out,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              status
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;
    state_t                   state, next;
    logic [COUNTER_WIDTH-1:0] phase, sh_period, sh_width;
    logic [COUNT_WIDTH-1:0]   sh_count, emitted, emitted_inc;
    logic                     overrun, cfg_error, aborted;
    logic                     cfg_ok, running, abort, high_end, low_end, start;
    always_comb begin
        cfg_ok      = cfg_period != '0 && cfg_width != '0 && cfg_count != '0 && cfg_width < cfg_period;
        running     = state == HIGH || state == LOW;
        abort       = running && !cfg_enable;
        high_end    = state == HIGH && phase == sh_width - 1'b1;
        low_end     = state == LOW && phase == sh_period - sh_width - 1'b1;
        emitted_inc = emitted + 1'b1;
        start       = state == IDLE && trigger && cfg_enable;
        next        = state;
        case (state)
            IDLE:    next = (start && cfg_ok) ? HIGH : IDLE;
            HIGH:    next = abort ? IDLE : (high_end ? LOW : HIGH);
            // abort takes priority over the end of a low phase; emitted still counts that pulse
            LOW:     next = abort ? IDLE : (low_end ? ((emitted_inc < sh_count) ? HIGH : DONE) : LOW);
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase     <= '0;
            sh_period <= '0;
            sh_width  <= '0;
            sh_count  <= '0;
            emitted   <= '0;
            overrun   <= 1'b0;
            cfg_error <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            // phase restarts on every state change, so it counts cycles within the current phase
            phase <= (next != state) ? '0 : phase + 1'b1;
            if (start) begin
                emitted   <= '0;
                aborted   <= 1'b0;
                overrun   <= 1'b0;
                cfg_error <= !cfg_ok;
                if (cfg_ok) begin
                    sh_period <= cfg_period;
                    sh_width  <= cfg_width;
                    sh_count  <= cfg_count;
                end
            end
            if (trigger && state != IDLE) overrun <= 1'b1;
            if (abort) aborted <= 1'b1;
            if (low_end) emitted <= emitted_inc;
        end
    end
    assign pulse_out = state == HIGH;
    assign busy      = running;
    assign done      = state == DONE;
    assign status    = {overrun, cfg_error, aborted, busy, 12'b0, 16'(emitted)};
endmodule

// File: tb/tb_axil_triggered_pulse_train.sv
// tb_axil_triggered_pulse_train: scoreboard bench; stimulus queues expected per-cycle observations, a monitor checks them.
module tb_axil_triggered_pulse_train;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] cfg_period = '0, cfg_width = '0, cfg_count = '0;
    logic        cfg_enable = 1'b1, trigger = 1'b0;
    logic        pulse_out, busy, done;
    logic [31:0] status;
    int          cyc = 0, checks = 0, errors = 0, done_seen = 0, done_exp = 0, n = 0;

    typedef struct {
        int          c;
        string       name;
        logic        p, b, d;
        logic [31:0] s;
    } exp_t;
    exp_t q[$];

    axil_triggered_pulse_train #(.COUNTER_WIDTH(16), .COUNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .cfg_period(cfg_period), .cfg_width(cfg_width),
        .cfg_count(cfg_count), .cfg_enable(cfg_enable), .trigger(trigger),
        .pulse_out(pulse_out), .busy(busy), .done(done), .status(status)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] st(logic ov, logic ce, logic ab, logic bz, int em);
        return {ov, ce, ab, bz, 12'b0, 16'(em)};
    endfunction

    task automatic expect_at(int c, string name, logic p, logic b, logic d, logic [31:0] s);
        exp_t e;
        e.c = c; e.name = name; e.p = p; e.b = b; e.d = d; e.s = s;
        q.push_back(e);
    endtask

    task automatic to_cycle(int t);
        while (cyc < t) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic fire(int p, int w, int k);
        cfg_period = 16'(p); cfg_width = 16'(w); cfg_count = 16'(k);
        trigger = 1'b1;
        to_cycle(cyc + 1);
        trigger = 1'b0;
    endtask

    always @(negedge clock) begin
        if (done) done_seen++;
        while (q.size() > 0 && q[0].c <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (e.c != cyc || pulse_out !== e.p || busy !== e.b || done !== e.d || status !== e.s) begin
                errors++;
                $display("FAIL %s cyc %0d (want cyc %0d): got pulse=%b busy=%b done=%b status=%h, want pulse=%b busy=%b done=%b status=%h",
                         e.name, cyc, e.c, pulse_out, busy, done, status, e.p, e.b, e.d, e.s);
            end
        end
    end

    initial begin
        to_cycle(3);
        expect_at(cyc, "reset", 0, 0, 0, 32'h0);
        to_cycle(4);
        reset = 1'b1;
        to_cycle(6);

        // basic train: 10/3/4
        n = cyc;
        expect_at(n + 1,  "t1_first_high", 1, 1, 0, st(0, 0, 0, 1, 0));
        expect_at(n + 3,  "t1_last_high",  1, 1, 0, st(0, 0, 0, 1, 0));
        expect_at(n + 4,  "t1_first_low",  0, 1, 0, st(0, 0, 0, 1, 0));
        expect_at(n + 10, "t1_last_low",   0, 1, 0, st(0, 0, 0, 1, 0));
        expect_at(n + 11, "t1_second_hi",  1, 1, 0, st(0, 0, 0, 1, 1));
        expect_at(n + 40, "t1_final_low",  0, 1, 0, st(0, 0, 0, 1, 3));
        expect_at(n + 41, "t1_done",       0, 0, 1, st(0, 0, 0, 0, 4));
        expect_at(n + 42, "t1_idle",       0, 0, 0, st(0, 0, 0, 0, 4));
        done_exp++;
        fire(10, 3, 4);
        to_cycle(n + 45);

        // invalid config: width == period
        n = cyc;
        expect_at(n + 1, "t2_cfg_error", 0, 0, 0, st(0, 1, 0, 0, 0));
        expect_at(n + 4, "t2_still_idle", 0, 0, 0, st(0, 1, 0, 0, 0));
        fire(5, 5, 2);
        to_cycle(n + 8);

        // overrun: retrigger during LOW
        n = cyc;
        expect_at(n + 1,  "t3_start",   1, 1, 0, st(0, 0, 0, 1, 0));
        expect_at(n + 6,  "t3_overrun", 0, 1, 0, st(1, 0, 0, 1, 0));
        expect_at(n + 9,  "t3_second",  1, 1, 0, st(1, 0, 0, 1, 1));
        expect_at(n + 25, "t3_done",    0, 0, 1, st(1, 0, 0, 0, 3));
        expect_at(n + 26, "t3_idle",    0, 0, 0, st(1, 0, 0, 0, 3));
        done_exp++;
        fire(8, 2, 3);
        to_cycle(n + 5);
        trigger = 1'b1;
        to_cycle(n + 6);
        trigger = 1'b0;
        to_cycle(n + 30);

        // abort by dropping enable in the third HIGH phase; also clears overrun on accept
        n = cyc;
        expect_at(n + 1,  "t4_start",     1, 1, 0, st(0, 0, 0, 1, 0));
        expect_at(n + 15, "t4_pre_abort", 1, 1, 0, st(0, 0, 0, 1, 2));
        expect_at(n + 16, "t4_aborted",   0, 0, 0, st(0, 0, 1, 0, 2));
        expect_at(n + 18, "t4_stays",     0, 0, 0, st(0, 0, 1, 0, 2));
        fire(6, 4, 10);
        to_cycle(n + 15);
        cfg_enable = 1'b0;
        to_cycle(n + 17);
        cfg_enable = 1'b1;
        to_cycle(n + 21);

        // shadow latch: period rewritten mid-train, width = period-1
        n = cyc;
        expect_at(n + 3, "t5_high",    1, 1, 0, st(0, 0, 0, 1, 0));
        expect_at(n + 4, "t5_one_low", 0, 1, 0, st(0, 0, 0, 1, 0));
        expect_at(n + 5, "t5_done",    0, 0, 1, st(0, 0, 0, 0, 1));
        done_exp++;
        fire(4, 3, 1);
        to_cycle(n + 2);
        cfg_period = 16'd100;
        to_cycle(n + 10);

        // reset mid-train, then a fresh train
        n = cyc;
        expect_at(n + 6, "t6_running",  0, 1, 0, st(0, 0, 0, 1, 0));
        expect_at(n + 7, "t6_reset",    0, 0, 0, 32'h0);
        expect_at(n + 11, "t6_fresh",   1, 1, 0, st(0, 0, 0, 1, 0));
        expect_at(n + 21, "t6_done",    0, 0, 1, st(0, 0, 0, 0, 1));
        done_exp++;
        fire(10, 3, 5);
        to_cycle(n + 7);
        reset = 1'b0;
        to_cycle(n + 9);
        reset = 1'b1;
        to_cycle(n + 10);
        fire(10, 3, 1);
        to_cycle(n + 24);

        // trigger with enable low is ignored
        n = cyc;
        expect_at(n + 1, "t7_ignored", 0, 0, 0, st(0, 0, 0, 0, 1));
        cfg_enable = 1'b0;
        fire(5, 5, 0);
        cfg_enable = 1'b1;
        to_cycle(n + 4);

        checks++;
        if (done_seen != done_exp) begin
            errors++;
            $display("FAIL done_count: got %0d, want %0d", done_seen, done_exp);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations: got %0d, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
